// File: rtl/display_objects_regs_axil.sv
// AXI4-Lite register slave for game-object display parameters. CPU-written shadow registers are
// copied to the renderer-facing active set only on a frame_start commit, so objects never tear.
module display_objects_regs_axil #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned NUM_STATUS = 2
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    input  logic                             frame_start,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   active_regs,
    output logic                             commit_pending,
    output logic                             commit_done
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned CTRL_IDX  = NUM_REGS;
    localparam int unsigned FCNT_IDX  = NUM_REGS + 1;
    localparam int unsigned STAT_BASE = NUM_REGS + 2;
    localparam int unsigned MAP_END   = NUM_REGS + 2 + NUM_STATUS;
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    logic                               ready_en_q;
    logic                               aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]              aw_addr_q, aw_addr_d;
    logic                               w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]              w_data_q, w_data_d;
    logic [STRB_W-1:0]                  w_strb_q, w_strb_d;
    logic                               bvalid_q, bvalid_d;
    logic [1:0]                         bresp_q, bresp_d;
    logic                               rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]              rdata_q, rdata_d;
    logic [1:0]                         rresp_q, rresp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] active_q, active_d;
    logic                               pending_q, pending_d;
    logic                               auto_q, auto_d;
    logic                               done_q, done_d;
    logic [DATA_WIDTH-1:0]              frame_cnt_q, frame_cnt_d;

    logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_err, commit_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [31:0]           wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_err;

    // Ready outputs stay low until the first cycle after reset is released.
    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign active_regs   = active_q;
    assign commit_pending = pending_q;
    assign commit_done   = done_q;

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
    // A write resolves as soon as both halves are present, held or arriving this cycle.
    assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_idx  = 32'(wr_addr[ADDR_WIDTH-1:2]);
    assign rd_idx  = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    assign wr_err  = (wr_idx >= MAP_END);
    assign commit_fire = frame_start & (pending_q | auto_q);

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (rd_idx < NUM_REGS) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (rd_idx == 32'(k)) rd_val = shadow_q[k];
            end
        end else if (rd_idx == CTRL_IDX) begin
            rd_val = {{(DATA_WIDTH-2){1'b0}}, auto_q, pending_q};
        end else if (rd_idx == FCNT_IDX) begin
            rd_val = frame_cnt_q;
        end else if (rd_idx < MAP_END) begin
            for (int k = 0; k < int'(NUM_STATUS); k++) begin
                if (rd_idx == 32'(STAT_BASE + 32'(k))) begin
                    rd_val = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        aw_held_d   = aw_held_q;
        aw_addr_d   = aw_addr_q;
        w_held_d    = w_held_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        auto_d      = auto_q;
        done_d      = commit_fire;
        frame_cnt_d = frame_cnt_q + DATA_WIDTH'(frame_start);

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        // Commit samples the pre-write shadow; a COMMIT write this cycle re-arms pending.
        if (commit_fire) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RespSlvErr : RespOkay;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (wr_idx == 32'(k)) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (wr_strb[b]) shadow_d[k][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            if (wr_idx == CTRL_IDX && wr_strb[0]) begin
                auto_d = wr_data[1];
                if (wr_data[0]) pending_d = 1'b1;
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? '0 : rd_val;
            rresp_d  = rd_err ? RespSlvErr : RespOkay;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ready_en_q  <= 1'b0;
            aw_held_q   <= 1'b0;
            aw_addr_q   <= '0;
            w_held_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RespOkay;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            auto_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            aw_held_q   <= aw_held_d;
            aw_addr_q   <= aw_addr_d;
            w_held_q    <= w_held_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            auto_q      <= auto_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: doc/display_objects_regs_axil.md
Name: display_objects_regs_axil

Overview:
Parametrised AXI4-Lite register slave holding game-object display parameters (positions/sizes) as shadow registers written by the CPU. The shadow set is copied to an active set, which drives the pixel renderer, only at frame boundaries, so objects never tear mid-frame. It also exposes a frame counter and read-only status words, for example collision flags and scores from the game logic. It generalises the fixed 4-register display slave with byte strobes, error responses, commit control and status readback.

Parameters:
DATA_WIDTH, 32, AXI data width and register width (32 only; other values unsupported).
ADDR_WIDTH, 6, AXI byte-address width; must satisfy 2^ADDR_WIDTH >= 4*(NUM_REGS+2+NUM_STATUS).
NUM_REGS, 8, number of RW shadow/active register pairs (1..16).
NUM_STATUS, 2, number of RO status words (0..8).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
frame_start  in  1  one-cycle pulse at start of vertical blank
status_in  in  NUM_STATUS*DATA_WIDTH  RO status words, word k at bits [32k+31:32k]
active_regs  out  NUM_REGS*DATA_WIDTH  active copy, reg k at bits [32k+31:32k]
commit_pending  out  1  commit requested, not yet applied
commit_done  out  1  one-cycle pulse, cycle after active update

Behaviour:
- Register map uses word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
  - idx 0..NUM_REGS-1: SHADOW (RW).
  - idx NUM_REGS: CTRL (RW). bit0 COMMIT: write 1 sets commit_pending; write 0 has no effect; reads as commit_pending. bit1 AUTO: commit every frame. Other bits read 0.
  - idx NUM_REGS+1: FRAME_CNT (RO). Increments on every frame_start and wraps at 2^32-1 -> 0.
  - idx NUM_REGS+2..NUM_REGS+1+NUM_STATUS: status_in words (RO), sampled at the read handshake.
  - Higher idx: unmapped.
- Reset: all SHADOW, active, CTRL and FRAME_CNT = 0. All READY/VALID outputs = 0, BRESP/RRESP = 0, RDATA = 0, commit_pending = 0, commit_done = 0. Reset mid-transaction abandons it: no B or R is issued for it.
- Write channel:
  - AWREADY=1 while no address is held and BVALID=0; WREADY=1 while no data is held and BVALID=0. AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - In the cycle after both are held, the write is performed, BVALID=1 and the holds are cleared. Minimum AW/W-to-BVALID latency is 1 cycle.
  - BVALID holds until BREADY. No new AW/W is accepted while BVALID=1.
  - WSTRB: byte lane i is written only if WSTRB[i]=1; WSTRB=0 is a legal no-op returning OKAY.
  - Writes to RO registers are ignored with BRESP=OKAY. Writes to unmapped addresses are ignored with BRESP=SLVERR (2'b10).
- Read channel:
  - ARREADY=1 while RVALID=0. On AR handshake, RDATA and RRESP are registered and RVALID=1 next cycle, held until RREADY.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
  - Read and write to the same register resolving in the same cycle: read returns the pre-write value.
- Commit (evaluated on the frame_start cycle):
  - If commit_pending=1 or AUTO=1: active <= shadow, commit_pending <= 0, commit_done=1 next cycle.
  - A COMMIT write performed in the same cycle as frame_start is not applied; commit_pending ends that cycle at 1 and the commit is applied at the next frame_start.
  - A SHADOW write in the same cycle as a commit: active receives the pre-write shadow value.
  - frame_start during reset is ignored.
- active_regs changes only on commit cycles.

Test Plan:
- Reset, then read every mapped idx -> all RDATA=0, RRESP=OKAY. Read idx NUM_REGS+2+NUM_STATUS -> RRESP=2'b10, RDATA=0.
- Write SHADOW0=0x00000001..SHADOW3=0x00000004, then read back -> values match, BRESP=OKAY, active_regs still 0. Write CTRL=0x1 -> commit_pending=1. Pulse frame_start -> active_regs[127:0]=0x00000004_00000003_00000002_00000001, commit_done pulses once, CTRL reads 0.
- SHADOW1=0xAABBCCDD, then write 0x11223344 with WSTRB=4'b0101 -> reads 0xAA22CC44. Write to unmapped idx -> BRESP=SLVERR and no register changes.
- AW issued 3 cycles before W; separately, W issued before AW; separately, BREADY held low 5 cycles -> each write performs exactly once, BVALID stays high until BREADY, AWREADY/WREADY stay 0 meanwhile.
- COMMIT write resolving in the same cycle as frame_start -> active unchanged, commit_pending=1; next frame_start applies it. AUTO=1 with 3 frame_start pulses -> 3 commit_done pulses, FRAME_CNT reads 3.
- status_in word0=0xDEADBEEF -> read idx NUM_REGS+2 returns 0xDEADBEEF. Writing it -> OKAY and value unchanged. ARESET asserted while RVALID=1 -> RVALID=0 next cycle and all registers return to 0.
